// File: rtl/alu_pkg.sv
// Shared definitions for the structural execute-stage ALU: datapath width
// and the 4-bit opcode encoding driven on the control input.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;

    // Opcodes that route through the subtract configuration of the adder chain.
    function automatic logic uses_sub(input logic [3:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_struct_cells.sv
// 1-bit building blocks for the ALU: a full adder and the three 2-input gates.
// The top replicates these per bit to form the ripple adder and logic units.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module and_gate (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = x & y;
endmodule

module or_gate (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = x | y;
endmodule

module xor_gate (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = x ^ y;
endmodule

// File: rtl/alu_struct.sv
// 32-bit execute-stage ALU assembled from 1-bit cells. A single ripple chain
// serves add, sub, slt and sltu (b is inverted by xor cells and carry-in set
// for the subtract forms). Result and flags are registered: one-cycle latency.
module alu_struct
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    logic             sub_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] xor_s;
    logic [WIDTH-1:0] sll_s;
    logic [WIDTH-1:0] srl_s;
    logic             carry_msb_s;
    logic             ovf_s;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    assign sub_s = uses_sub(control);

    // Per-bit cells: operand-b conditioner, full adder (carry chained through
    // each generate block's own carry wire) and the three logic gates.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic cin_s;
        logic cout_s;

        if (i == 0) begin : g_lsb
            assign cin_s = sub_s;
        end else begin : g_chain
            assign cin_s = g_bit[i-1].cout_s;
        end

        xor_gate u_binv (
            .x (operand_b[i]),
            .y (sub_s),
            .z (b_eff_s[i])
        );

        fulladder u_fa (
            .a         (operand_a[i]),
            .b         (b_eff_s[i]),
            .carry_in  (cin_s),
            .sum       (sum_s[i]),
            .carry_out (cout_s)
        );

        and_gate u_and (
            .x (operand_a[i]),
            .y (operand_b[i]),
            .z (and_s[i])
        );

        or_gate u_or (
            .x (operand_a[i]),
            .y (operand_b[i]),
            .z (or_s[i])
        );

        xor_gate u_xor (
            .x (operand_a[i]),
            .y (operand_b[i]),
            .z (xor_s[i])
        );
    end

    assign carry_msb_s = g_bit[WIDTH-1].cout_s;

    // With b already conditioned, one formula covers both add and sub overflow.
    assign ovf_s = (operand_a[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                   (sum_s[WIDTH-1] != operand_a[WIDTH-1]);

    // Five-stage logical barrel shifters; only operand_b[4:0] is the amount.
    always_comb begin
        sll_s = operand_a;
        srl_s = operand_a;
        for (int k = 0; k < 5; k++) begin
            if (operand_b[k]) begin
                sll_s = sll_s << (32'd1 << k);
                srl_s = srl_s >> (32'd1 << k);
            end else begin
                sll_s = sll_s;
                srl_s = srl_s;
            end
        end
    end

    // Output select by opcode; flags only meaningful for add/sub.
    always_comb begin
        result_d = {WIDTH{1'b0}};
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (control)
            ALU_ADD: begin
                result_d = sum_s;
                carry_d  = carry_msb_s;
                ovf_d    = ovf_s;
            end
            ALU_SUB: begin
                result_d = sum_s;
                carry_d  = carry_msb_s;
                ovf_d    = ovf_s;
            end
            ALU_AND:  result_d = and_s;
            ALU_XOR:  result_d = xor_s;
            ALU_OR:   result_d = or_s;
            ALU_SLL:  result_d = sll_s;
            ALU_SRL:  result_d = srl_s;
            ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
            ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, ~carry_msb_s};
            default: begin
                result_d = {WIDTH{1'b0}};
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
            end
        endcase
        zero_d = (result_d == {WIDTH{1'b0}});
    end

    // Output register; reset leaves a zero result with the zero flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign result   = result_q;
    assign carryout = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_struct.sv
// Directed-vector bench for alu_struct with hand-computed expected values.
module tb_alu_struct;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  control;
    logic [31:0] result;
    logic        carryout;
    logic        overflow;
    logic        zero;

    int n_vec;
    int n_bad;

    alu_struct dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .control   (control),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] r, input logic c,
                              input logic v, input logic z);
        check_val({tag, ".result"},   result,            r);
        check_val({tag, ".carryout"}, {31'd0, carryout}, {31'd0, c});
        check_val({tag, ".overflow"}, {31'd0, overflow}, {31'd0, v});
        check_val({tag, ".zero"},     {31'd0, zero},     {31'd0, z});
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r, input logic c,
                           input logic v, input logic z);
        @(negedge clk);
        control   = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        check_outs(tag, r, c, v, z);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        control   = 4'd0;
        operand_a = 32'h0000_0005;
        operand_b = 32'h0000_0007;

        // Reset state held across clock edges while rst_n is low.
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 32'h0, 1'b0, 1'b0, 1'b1);

        // Release between edges: outputs hold until the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("release_hold", 32'h0, 1'b0, 1'b0, 1'b1);

        // Add
        run_vec("add_1_1",      4'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_vec("add_wrap",     4'd0, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_vec("add_ovf",      4'd0, 32'h7fff_ffff, 32'h7fff_ffff, 32'hffff_fffe, 1'b0, 1'b1, 1'b0);
        run_vec("add_noovf",    4'd0, 32'h1000_0000, 32'h1000_0000, 32'h2000_0000, 1'b0, 1'b0, 1'b0);
        // Sub
        run_vec("sub_16_8",     4'd1, 32'd16,        32'd8,         32'h0000_0008, 1'b1, 1'b0, 1'b0);
        run_vec("sub_8_16",     4'd1, 32'd8,         32'd16,        32'hffff_fff8, 1'b0, 1'b0, 1'b0);
        run_vec("sub_0_1",      4'd1, 32'h0000_0000, 32'h0000_0001, 32'hffff_ffff, 1'b0, 1'b0, 1'b0);
        run_vec("sub_ovf",      4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7fff_ffff, 1'b1, 1'b1, 1'b0);
        run_vec("sub_eq",       4'd1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        // Logic
        run_vec("and_ones",     4'd2, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 1'b0, 1'b0);
        run_vec("and_mix",      4'd2, 32'hf0f0_1234, 32'h0ff0_ff00, 32'h00f0_1200, 1'b0, 1'b0, 1'b0);
        run_vec("xor_ones",     4'd3, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("xor_mix",      4'd3, 32'ha5a5_0f0f, 32'h0ff0_ffff, 32'haa55_f0f0, 1'b0, 1'b0, 1'b0);
        run_vec("or_ones",      4'd4, 32'hffff_ffff, 32'h0000_0000, 32'hffff_ffff, 1'b0, 1'b0, 1'b0);
        run_vec("or_mix",       4'd4, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0, 1'b0, 1'b0);
        // Shifts
        run_vec("sll_c",        4'd5, 32'hffff_fff0, 32'h0000_000c, 32'hffff_0000, 1'b0, 1'b0, 1'b0);
        run_vec("sll_10",       4'd5, 32'h0000_ffff, 32'h0000_0010, 32'hffff_0000, 1'b0, 1'b0, 1'b0);
        run_vec("sll_1",        4'd5, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_vec("sll_31",       4'd5, 32'h0000_0003, 32'h0000_001f, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run_vec("sll_amt0_hi",  4'd5, 32'h1234_5678, 32'hffff_ffe0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        run_vec("srl_10",       4'd6, 32'hffff_0000, 32'h0000_0010, 32'h0000_ffff, 1'b0, 1'b0, 1'b0);
        run_vec("srl_out",      4'd6, 32'h0000_ffff, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("srl_hi_ign",   4'd6, 32'h8000_0000, 32'hffff_ffe7, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        // Compare
        run_vec("slt_pos_neg",  4'd7, 32'h0000_ffff, 32'hffff_ffff, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("slt_neg_pos",  4'd7, 32'hffff_ff00, 32'h00ff_ffff, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_vec("slt_ovfcase",  4'd7, 32'h8000_0000, 32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_vec("sltu_lt",      4'd8, 32'h0000_ffff, 32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_vec("sltu_ge",      4'd8, 32'hffff_ffff, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("sltu_eq",      4'd8, 32'h0000_0042, 32'h0000_0042, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        // Unused opcodes
        run_vec("op9",          4'd9, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("op15",         4'd15, 32'h7fff_ffff, 32'h7fff_ffff, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        // Load a non-zero result with flags set, then reset between edges.
        run_vec("pre_reset",    4'd0, 32'hffff_ffff, 32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_reset",   4'd1, 32'h0000_0003, 32'h0000_0005, 32'hffff_fffe, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
